// File: rtl/vga_timer_cfg.sv
// Parametrised VGA/VESA raster timing generator: pixel prescaler, h/v counters,
// registered sync/visible outputs aligned with the counters, line/frame strobes and frame counter.
module vga_timer_cfg #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int CLK_DIV     = 1,
  parameter int FRAME_CNT_W = 16,
  localparam int XW = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1,
  localparam int YW = (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  output logic                   pixel_en_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   visible_o,
  output logic [XW-1:0]          position_x_o,
  output logic [YW-1:0]          position_y_o,
  output logic                   line_start_o,
  output logic                   frame_start_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP_END = HW'(H_DISPLAY);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_DISPLAY + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP_END = VW'(V_DISPLAY);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_DISPLAY + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_DISPLAY + V_FP + V_SYNC);
  localparam logic          H_ACT      = 1'(HSYNC_POL != 0);
  localparam logic          V_ACT      = 1'(VSYNC_POL != 0);

  if (H_DISPLAY < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_DISPLAY < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CLK_DIV < 1 || FRAME_CNT_W < 1) begin : g_param_err
    $error("vga_timer_cfg: display/porch/sync sizes, CLK_DIV and FRAME_CNT_W must all be >= 1");
  end

  logic [DW-1:0]          div_q, div_d;
  logic [HW-1:0]          h_q, h_d;
  logic [VW-1:0]          v_q, v_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   visible_q, visible_d;
  logic                   tick;

  assign tick = en_i && (div_q == DIV_LAST);

  always_comb begin
    div_d   = div_q;
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (en_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = frame_q + FRAME_CNT_W'(1);
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end
    // Decoded from the next counter values so the registered pins line up with h_q/v_q.
    hsync_d   = ((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END)) ? H_ACT : ~H_ACT;
    vsync_d   = ((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END)) ? V_ACT : ~V_ACT;
    visible_d = (h_d < H_DISP_END) && (v_d < V_DISP_END);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      frame_q   <= '0;
      hsync_q   <= ~H_ACT;
      vsync_q   <= ~V_ACT;
      visible_q <= 1'b1;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      frame_q   <= frame_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      visible_q <= visible_d;
    end
  end

  // Strobes are forced low while reset is held, even though the counters sit at (0,0).
  assign pixel_en_o    = tick && !rst_i;
  assign line_start_o  = pixel_en_o && (h_q == '0);
  assign frame_start_o = pixel_en_o && (h_q == '0) && (v_q == '0);
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign visible_o     = visible_q;
  assign frame_count_o = frame_q;
  assign position_x_o  = (h_q < H_DISP_END) ? h_q[XW-1:0] : '0;
  assign position_y_o  = (v_q < V_DISP_END) ? v_q[YW-1:0] : '0;

endmodule

// File: tb/tb_vga_timer_cfg.sv
// Scoreboard bench for vga_timer_cfg: four configurations, expected outputs derived
// arithmetically from the number of enabled clocks since reset.
`timescale 1ns/1ps
module tb_vga_timer_cfg;

  typedef struct {
    int hd, hf, hs, hb, vd, vf, vs, vb, hp, vp, dv, fw;
  } cfg_t;

  cfg_t cfg_def, cfg_div, cfg_pol, cfg_tiny;
  int   vectors = 0;
  int   miscompares = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundle: {pad, frame_count, y, x, visible, vsync, hsync, frame_start, line_start, pixel_en}
  function automatic logic [63:0] model(cfg_t c, int n, logic en, logic rst);
    int ht, vt, p, d, h, v, f;
    logic tick, hs, vs, vis;
    logic [15:0] xp, yp, fc;
    ht   = c.hd + c.hf + c.hs + c.hb;
    vt   = c.vd + c.vf + c.vs + c.vb;
    p    = n / c.dv;
    d    = n % c.dv;
    h    = p % ht;
    v    = (p / ht) % vt;
    f    = (p / (ht * vt)) % (1 << c.fw);
    tick = en && !rst && (d == c.dv - 1);
    hs   = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? (c.hp != 0) : (c.hp == 0);
    vs   = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? (c.vp != 0) : (c.vp == 0);
    vis  = (h < c.hd) && (v < c.vd);
    xp   = (h < c.hd) ? 16'(h) : 16'd0;
    yp   = (v < c.vd) ? 16'(v) : 16'd0;
    fc   = 16'(f);
    return {10'd0, fc, yp, xp, vis, vs, hs, tick && h == 0 && v == 0, tick && h == 0, tick};
  endfunction

  // Default 640x480 timing
  logic rst_def = 1'b1, en_def = 1'b1;
  logic pe_def, hs_def, vs_def, vis_def, ls_def, fs_def;
  logic [9:0] x_def; logic [8:0] y_def; logic [15:0] fc_def;
  vga_timer_cfg u_def (
    .clk_i(clk), .rst_i(rst_def), .en_i(en_def), .pixel_en_o(pe_def), .hsync_o(hs_def),
    .vsync_o(vs_def), .visible_o(vis_def), .position_x_o(x_def), .position_y_o(y_def),
    .line_start_o(ls_def), .frame_start_o(fs_def), .frame_count_o(fc_def));
  wire [63:0] obs_def = {10'd0, fc_def, 7'd0, y_def, 6'd0, x_def, vis_def, vs_def, hs_def, fs_def, ls_def, pe_def};

  // Default timing, prescaler 4
  logic rst_div = 1'b1, en_div = 1'b1;
  logic pe_div, hs_div, vs_div, vis_div, ls_div, fs_div;
  logic [9:0] x_div; logic [8:0] y_div; logic [15:0] fc_div;
  vga_timer_cfg #(.CLK_DIV(4)) u_div (
    .clk_i(clk), .rst_i(rst_div), .en_i(en_div), .pixel_en_o(pe_div), .hsync_o(hs_div),
    .vsync_o(vs_div), .visible_o(vis_div), .position_x_o(x_div), .position_y_o(y_div),
    .line_start_o(ls_div), .frame_start_o(fs_div), .frame_count_o(fc_div));
  wire [63:0] obs_div = {10'd0, fc_div, 7'd0, y_div, 6'd0, x_div, vis_div, vs_div, hs_div, fs_div, ls_div, pe_div};

  // Small mode, active-high syncs
  logic rst_pol = 1'b1, en_pol = 1'b1;
  logic pe_pol, hs_pol, vs_pol, vis_pol, ls_pol, fs_pol;
  logic [2:0] x_pol; logic [2:0] y_pol; logic [15:0] fc_pol;
  vga_timer_cfg #(.H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_DISPLAY(6), .V_FP(1),
                  .V_SYNC(2), .V_BP(2), .HSYNC_POL(1), .VSYNC_POL(1)) u_pol (
    .clk_i(clk), .rst_i(rst_pol), .en_i(en_pol), .pixel_en_o(pe_pol), .hsync_o(hs_pol),
    .vsync_o(vs_pol), .visible_o(vis_pol), .position_x_o(x_pol), .position_y_o(y_pol),
    .line_start_o(ls_pol), .frame_start_o(fs_pol), .frame_count_o(fc_pol));
  wire [63:0] obs_pol = {10'd0, fc_pol, 13'd0, y_pol, 13'd0, x_pol, vis_pol, vs_pol, hs_pol, fs_pol, ls_pol, pe_pol};

  // Tiny mode, 2-bit frame counter
  logic rst_tny = 1'b1, en_tny = 1'b1;
  logic pe_tny, hs_tny, vs_tny, vis_tny, ls_tny, fs_tny;
  logic [1:0] x_tny; logic [1:0] y_tny; logic [1:0] fc_tny;
  vga_timer_cfg #(.H_DISPLAY(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_DISPLAY(3), .V_FP(1),
                  .V_SYNC(1), .V_BP(1), .FRAME_CNT_W(2)) u_tny (
    .clk_i(clk), .rst_i(rst_tny), .en_i(en_tny), .pixel_en_o(pe_tny), .hsync_o(hs_tny),
    .vsync_o(vs_tny), .visible_o(vis_tny), .position_x_o(x_tny), .position_y_o(y_tny),
    .line_start_o(ls_tny), .frame_start_o(fs_tny), .frame_count_o(fc_tny));
  wire [63:0] obs_tny = {10'd0, 14'd0, fc_tny, 14'd0, y_tny, 14'd0, x_tny, vis_tny, vs_tny, hs_tny, fs_tny, ls_tny, pe_tny};

  task automatic test_reset();
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    @(negedge clk);
    sb.push_back(model(cfg_def, 0, en_def, 1'b1));
    sb.push_back(model(cfg_div, 0, en_div, 1'b1));
    sb.push_back(model(cfg_pol, 0, en_pol, 1'b1));
    sb.push_back(model(cfg_tiny, 0, en_tny, 1'b1));
    exp_v = sb.pop_front(); vectors++;
    if (obs_def !== exp_v) begin miscompares++; $display("FAIL reset_def got=%h exp=%h", obs_def, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (obs_div !== exp_v) begin miscompares++; $display("FAIL reset_div got=%h exp=%h", obs_div, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (obs_pol !== exp_v) begin miscompares++; $display("FAIL reset_pol got=%h exp=%h", obs_pol, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (obs_tny !== exp_v) begin miscompares++; $display("FAIL reset_tiny got=%h exp=%h", obs_tny, exp_v); end
    vectors++;
    if (hs_pol !== 1'b0 || vs_pol !== 1'b0) begin
      miscompares++; $display("FAIL reset_pol_sync hs=%b vs=%b exp 0 0", hs_pol, vs_pol);
    end
    $display("test_reset: reset state checked on four instances");
  endtask

  task automatic test_hsync_default();
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    int n, low_run, falls[$];
    logic prev_hs;
    @(negedge clk); rst_def = 1'b1; en_def = 1'b1;
    @(negedge clk); rst_def = 1'b0;
    n = 0; low_run = 0; prev_hs = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      if (en_def) n++;
      sb.push_back(model(cfg_def, n, en_def, 1'b0));
      @(negedge clk);
      exp_v = sb.pop_front(); vectors++;
      if (obs_def !== exp_v) begin miscompares++; $display("FAIL hsync_default n=%0d got=%h exp=%h", n, obs_def, exp_v); end
      if (prev_hs && !hs_def) falls.push_back(n);
      if (!hs_def && n <= 800) low_run++;
      prev_hs = hs_def;
    end
    vectors++;
    if (falls.size() < 2) begin
      miscompares++; $display("FAIL hsync_falls got=%0d exp>=2", falls.size());
    end else begin
      if (falls[0] != 656) begin miscompares++; $display("FAIL hsync_first_fall got=%0d exp=656", falls[0]); end
      vectors++;
      if (falls[1] - falls[0] != 800) begin miscompares++; $display("FAIL hsync_period got=%0d exp=800", falls[1] - falls[0]); end
    end
    vectors++;
    if (low_run != 96) begin miscompares++; $display("FAIL hsync_width got=%0d exp=96", low_run); end
    $display("test_hsync_default: %0d falls, low width %0d", falls.size(), low_run);
  endtask

  task automatic test_enable_freeze();
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    int n;
    @(negedge clk); rst_def = 1'b1; en_def = 1'b1;
    @(negedge clk); rst_def = 1'b0;
    n = 0;
    for (int i = 0; i < 1130; i++) begin
      en_def = !(i >= 1100 && i < 1110);
      if (en_def) n++;
      sb.push_back(model(cfg_def, n, en_def, 1'b0));
      @(negedge clk);
      exp_v = sb.pop_front(); vectors++;
      if (obs_def !== exp_v) begin miscompares++; $display("FAIL enable_freeze i=%0d got=%h exp=%h", i, obs_def, exp_v); end
      if (i == 1109) begin
        vectors++;
        if (x_def !== 10'd300 || y_def !== 9'd1 || pe_def !== 1'b0) begin
          miscompares++; $display("FAIL freeze_hold x=%0d y=%0d pe=%b exp x=300 y=1 pe=0", x_def, y_def, pe_def);
        end
      end
      if (i == 1110) begin
        vectors++;
        if (x_def !== 10'd301) begin miscompares++; $display("FAIL freeze_resume x=%0d exp=301", x_def); end
      end
    end
    en_def = 1'b1;
    $display("test_enable_freeze: held 10 clk at x=300 y=1, resumed");
  endtask

  task automatic test_async_reset();
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    int n;
    @(negedge clk); rst_def = 1'b1; en_def = 1'b1;
    @(negedge clk); rst_def = 1'b0;
    n = 0;
    for (int i = 0; i < 700; i++) begin
      n++;
      sb.push_back(model(cfg_def, n, en_def, 1'b0));
      @(negedge clk);
      exp_v = sb.pop_front(); vectors++;
      if (obs_def !== exp_v) begin miscompares++; $display("FAIL async_pre n=%0d got=%h exp=%h", n, obs_def, exp_v); end
    end
    #2 rst_def = 1'b1;
    #1;
    sb.push_back(model(cfg_def, 0, en_def, 1'b1));
    exp_v = sb.pop_front(); vectors++;
    if (obs_def !== exp_v) begin miscompares++; $display("FAIL async_immediate got=%h exp=%h", obs_def, exp_v); end
    @(negedge clk);
    rst_def = 1'b0;
    n = 0;
    #1;
    sb.push_back(model(cfg_def, 0, en_def, 1'b0));
    exp_v = sb.pop_front(); vectors++;
    if (obs_def !== exp_v) begin miscompares++; $display("FAIL async_release got=%h exp=%h", obs_def, exp_v); end
    for (int i = 0; i < 20; i++) begin
      n++;
      sb.push_back(model(cfg_def, n, en_def, 1'b0));
      @(negedge clk);
      exp_v = sb.pop_front(); vectors++;
      if (obs_def !== exp_v) begin miscompares++; $display("FAIL async_restart n=%0d got=%h exp=%h", n, obs_def, exp_v); end
    end
    $display("test_async_reset: reset mid-line at x-count 700, restarted from (0,0)");
  endtask

  task automatic test_clk_div();
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    int n, pe_cnt, ls_cnt, ls_at[$];
    @(negedge clk); rst_div = 1'b1; en_div = 1'b1;
    @(negedge clk); rst_div = 1'b0;
    n = 0; pe_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 3300; i++) begin
      n++;
      sb.push_back(model(cfg_div, n, en_div, 1'b0));
      @(negedge clk);
      exp_v = sb.pop_front(); vectors++;
      if (obs_div !== exp_v) begin miscompares++; $display("FAIL clk_div n=%0d got=%h exp=%h", n, obs_div, exp_v); end
      if (ls_div) ls_at.push_back(n);
      if (n <= 3200) begin
        if (pe_div) pe_cnt++;
        if (ls_div) ls_cnt++;
      end
    end
    vectors++;
    if (pe_cnt != 800) begin miscompares++; $display("FAIL div_pixel_count got=%0d exp=800", pe_cnt); end
    vectors++;
    if (ls_cnt != 1) begin miscompares++; $display("FAIL div_line_strobes got=%0d exp=1", ls_cnt); end
    vectors++;
    if (ls_at.size() < 2) begin
      miscompares++; $display("FAIL div_line_count got=%0d exp>=2", ls_at.size());
    end else if (ls_at[1] - ls_at[0] != 3200) begin
      miscompares++; $display("FAIL div_line_period got=%0d exp=3200", ls_at[1] - ls_at[0]);
    end
    $display("test_clk_div: %0d pixel strobes per line, %0d line strobes", pe_cnt, ls_cnt);
  endtask

  task automatic test_polarity();
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    int n, vis_cnt, hs_cnt, vs_cnt;
    @(negedge clk); rst_pol = 1'b1; en_pol = 1'b1;
    @(negedge clk); rst_pol = 1'b0;
    n = 0; vis_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      n++;
      sb.push_back(model(cfg_pol, n, en_pol, 1'b0));
      @(negedge clk);
      exp_v = sb.pop_front(); vectors++;
      if (obs_pol !== exp_v) begin miscompares++; $display("FAIL polarity n=%0d got=%h exp=%h", n, obs_pol, exp_v); end
      if (n <= 165) begin
        if (vis_pol) vis_cnt++;
        if (hs_pol) hs_cnt++;
        if (vs_pol) vs_cnt++;
      end
    end
    vectors++;
    if (vis_cnt != 48) begin miscompares++; $display("FAIL pol_visible got=%0d exp=48", vis_cnt); end
    vectors++;
    if (hs_cnt != 33) begin miscompares++; $display("FAIL pol_hsync_high got=%0d exp=33", hs_cnt); end
    vectors++;
    if (vs_cnt != 30) begin miscompares++; $display("FAIL pol_vsync_high got=%0d exp=30", vs_cnt); end
    $display("test_polarity: per frame visible=%0d hsync_hi=%0d vsync_hi=%0d", vis_cnt, hs_cnt, vs_cnt);
  endtask

  task automatic test_frame_count();
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    int n, chg_n[$], chg_v[$], chg_fs[$];
    logic [1:0] prev_fc;
    @(negedge clk); rst_tny = 1'b1; en_tny = 1'b1;
    @(negedge clk); rst_tny = 1'b0;
    n = 0; prev_fc = 2'd0;
    for (int i = 0; i < 200; i++) begin
      n++;
      sb.push_back(model(cfg_tiny, n, en_tny, 1'b0));
      @(negedge clk);
      exp_v = sb.pop_front(); vectors++;
      if (obs_tny !== exp_v) begin miscompares++; $display("FAIL frame_count n=%0d got=%h exp=%h", n, obs_tny, exp_v); end
      if (fc_tny !== prev_fc) begin
        chg_n.push_back(n); chg_v.push_back(int'(fc_tny)); chg_fs.push_back(int'(fs_tny));
      end
      prev_fc = fc_tny;
    end
    vectors++;
    if (chg_n.size() != 4) begin
      miscompares++; $display("FAIL frame_changes got=%0d exp=4", chg_n.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (chg_n[k] != 42 * (k + 1) || chg_v[k] != (k + 1) % 4 || chg_fs[k] != 1) begin
          miscompares++;
          $display("FAIL frame_step%0d got n=%0d cnt=%0d fs=%0d exp n=%0d cnt=%0d fs=1",
                   k, chg_n[k], chg_v[k], chg_fs[k], 42 * (k + 1), (k + 1) % 4);
        end
        $display("test_frame_count: frame %0d complete at clk %0d, count=%0d", k + 1, chg_n[k], chg_v[k]);
      end
    end
  endtask

  initial begin
    cfg_def  = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1, 16};
    cfg_div  = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 4, 16};
    cfg_pol  = '{8, 2, 3, 2, 6, 1, 2, 2, 1, 1, 1, 16};
    cfg_tiny = '{4, 1, 1, 1, 3, 1, 1, 1, 0, 0, 1, 2};
    test_reset();
    test_hsync_default();
    test_enable_freeze();
    test_async_reset();
    test_clk_div();
    test_polarity();
    test_frame_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
